dot_argmax: RTL



---
 rtl/dot_argmax_if.sv | 36 +++
 rtl/dot_argmax.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dot_argmax_if.sv
// dot_argmax_if: stream bundle between the dot stage, dot_argmax and the
// result consumer.
//
// Signals:
//   INPUT_AXIS_TDATA   [31:0]  score, float32 bit pattern
//   INPUT_AXIS_TLAST           last score of the frame
//   INPUT_AXIS_TVALID          input beat valid
//   INPUT_AXIS_TREADY          argmax block can accept a score
//   OUTPUT_AXIS_TDATA  [31:0]  result word (or best value beat)
//   OUTPUT_AXIS_TLAST          last result beat of the frame
//   OUTPUT_AXIS_TVALID         result valid
//   OUTPUT_AXIS_TREADY         downstream ready
//
// Modports:
//   master - the environment: drives scores and the result ready.
//   slave  - dot_argmax: consumes scores and drives the result.
interface dot_argmax_if;
    logic [31:0] INPUT_AXIS_TDATA;
    logic        INPUT_AXIS_TLAST;
    logic        INPUT_AXIS_TVALID;
    logic        INPUT_AXIS_TREADY;
    logic [31:0] OUTPUT_AXIS_TDATA;
    logic        OUTPUT_AXIS_TLAST;
    logic        OUTPUT_AXIS_TVALID;
    logic        OUTPUT_AXIS_TREADY;

    modport master (
        output INPUT_AXIS_TDATA, INPUT_AXIS_TLAST, INPUT_AXIS_TVALID, OUTPUT_AXIS_TREADY,
        input  INPUT_AXIS_TREADY, OUTPUT_AXIS_TDATA, OUTPUT_AXIS_TLAST, OUTPUT_AXIS_TVALID
    );

    modport slave (
        input  INPUT_AXIS_TDATA, INPUT_AXIS_TLAST, INPUT_AXIS_TVALID, OUTPUT_AXIS_TREADY,
        output INPUT_AXIS_TREADY, OUTPUT_AXIS_TDATA, OUTPUT_AXIS_TLAST, OUTPUT_AXIS_TVALID
    );
endinterface

// File: rtl/dot_argmax.sv
// dot_argmax: classification step after the dot stage. Collects N float32
// scores per frame, tracks the index of the largest one by comparing raw bit
// patterns through an order-preserving key, and emits one result word.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   axis  dot_argmax_if.slave (scores in, result out)
//
// Result word: [IDX_W-1:0] best index, bit 30 NONE (all scores NaN),
// bit 31 FRAMING (TLAST missing on beat N or early), other bits zero.
//
// Build option DOT_ARGMAX_VALUE_EN: when defined, a second beat carrying the
// best score's raw bits (0x7FC00000 when NONE) follows the result word.
module dot_argmax #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input logic        clk,
    input logic        rst,
    dot_argmax_if.slave axis
);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [31:0]      best_key_q, best_key_d;
    logic             have_q, have_d;     // a non-NaN score has been seen this frame
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [31:0]      out_data_q;
`ifdef DOT_ARGMAX_VALUE_EN
    logic [31:0]      best_val_q, best_val_d;
    logic             beat_q;             // 0: result word on the bus, 1: value beat
`endif

    logic             accept;
    logic             beat_nan;
    logic             beat_upd;
    logic             frame_end;
    logic             framing_d;
    logic [31:0]      beat_key;
    logic [31:0]      result_d;

    // Map float bits to a key whose unsigned order matches numeric order.
    // Both zeros fold to the same key so -0.0 and +0.0 tie.
    function automatic logic [31:0] order_key(input logic [31:0] bits);
        logic [31:0] b;
        b = bits;
        if (b[30:0] == 31'd0)
            b = 32'd0;
        return b[31] ? ~b : (b | 32'h8000_0000);
    endfunction

    // NOTE: every signal written here gets a value on every path (defaults at
    // the top), so the block stays purely combinational and infers no latch.
    always_comb begin
        accept     = axis.INPUT_AXIS_TVALID && in_ready_q;
        beat_nan   = (axis.INPUT_AXIS_TDATA[30:23] == 8'hFF) &&
                     (axis.INPUT_AXIS_TDATA[22:0] != 23'd0);
        beat_key   = order_key(axis.INPUT_AXIS_TDATA);
        // First valid score always loads; later ones must be strictly
        // greater, so ties keep the lowest index.
        beat_upd   = !beat_nan && (!have_q || (beat_key > best_key_q));
        best_idx_d = beat_upd ? count_q  : best_idx_q;
        best_key_d = beat_upd ? beat_key : best_key_q;
        have_d     = have_q || !beat_nan;
`ifdef DOT_ARGMAX_VALUE_EN
        best_val_d = beat_upd ? axis.INPUT_AXIS_TDATA : best_val_q;
`endif
        frame_end  = axis.INPUT_AXIS_TLAST || (count_q == LAST_CNT);
        // Framing error: TLAST early, or absent on the N-th beat.
        framing_d  = axis.INPUT_AXIS_TLAST != (count_q == LAST_CNT);

        result_d              = '0;
        result_d[IDX_W-1:0]   = best_idx_d;
        result_d[30]          = !have_d;
        result_d[31]          = framing_d;
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            best_idx_q  <= '0;
            best_key_q  <= '0;
            have_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
`ifdef DOT_ARGMAX_VALUE_EN
            best_val_q  <= '0;
            beat_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        best_idx_q <= best_idx_d;
                        best_key_q <= best_key_d;
                        have_q     <= have_d;
`ifdef DOT_ARGMAX_VALUE_EN
                        best_val_q <= best_val_d;
`endif
                        if (frame_end) begin
                            // Result goes valid on the edge that takes the last score.
                            count_q     <= '0;
                            state_q     <= EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= result_d;
`ifdef DOT_ARGMAX_VALUE_EN
                            out_last_q  <= 1'b0;
                            beat_q      <= 1'b0;
`else
                            out_last_q  <= 1'b1;
`endif
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end

                EMIT: begin
                    // out_valid_q is high for the whole of EMIT, so READY alone
                    // completes a beat; otherwise data/last simply hold.
                    if (axis.OUTPUT_AXIS_TREADY) begin
`ifdef DOT_ARGMAX_VALUE_EN
                        if (!beat_q) begin
                            beat_q     <= 1'b1;
                            out_data_q <= have_q ? best_val_q : QNAN;
                            out_last_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q     <= COLLECT;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            best_idx_q  <= '0;
                            best_key_q  <= '0;
                            have_q      <= 1'b0;
`ifdef DOT_ARGMAX_VALUE_EN
                            best_val_q  <= '0;
                            beat_q      <= 1'b0;
`endif
                        end
                    end
                end

                default: state_q <= COLLECT;
            endcase
        end
    end

    assign axis.INPUT_AXIS_TREADY  = in_ready_q;
    assign axis.OUTPUT_AXIS_TVALID = out_valid_q;
    assign axis.OUTPUT_AXIS_TLAST  = out_last_q;
    assign axis.OUTPUT_AXIS_TDATA  = out_data_q;
endmodule
